// File: rtl/sifive_insight_tlb_pkg.sv
// Shared types for the hart-0 instruction TileLink B-channel Insight capture stage.
// Build option: SIFIVE_INSIGHT_TLB_DATA_EN (payload capture, see top level).
package sifive_insight_tlb_pkg;

    localparam logic [2:0] OpPutFull    = 3'd0;
    localparam logic [2:0] OpPutPartial = 3'd1;
    localparam logic [2:0] OpArithmetic = 3'd2;
    localparam logic [2:0] OpLogical    = 3'd3;
    localparam logic [2:0] OpGet        = 3'd4;
    localparam logic [2:0] OpIntent     = 3'd5;
    localparam logic [2:0] OpProbe      = 3'd6;

    // Widest supported timestamp; narrower counters are zero-extended into the record.
    localparam int unsigned RecTsW = 32;

    typedef struct packed {
        logic [RecTsW-1:0] ts;
        logic [2:0]        opcode;
        logic [1:0]        param;
        logic [3:0]        size;
        logic              source;
        logic [31:0]       address;
        logic [3:0]        mask;
        logic [31:0]       data;
        logic              corrupt;
        logic [7:0]        beat_idx;
        logic              first;
        logic              last;
    } capture_rec_t;

    // Data-carrying opcodes wider than one 32-bit beat span several beats; size > 10 cannot
    // occur on this bus and collapses to a single beat.
    function automatic logic [8:0] beats_of(input logic [2:0] opcode, input logic [3:0] size);
        logic [8:0] beats;
        beats = 9'd1;
        if (opcode <= OpLogical && size > 4'd2 && size <= 4'd10) begin
            beats = 9'd1 << (size - 4'd2);
        end
        return beats;
    endfunction

endpackage

// File: rtl/sifive_insight_capture_fifo.sv
// Small synchronous FIFO for capture records; registered storage, head read combinationally.
module sifive_insight_capture_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     wdata_i,
    input  logic pop_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);
    localparam logic [PtrW:0]   CntMax = (PtrW + 1)'(DEPTH);

    T                mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q;
    logic [PtrW-1:0] rptr_q;
    logic [PtrW:0]   count_q;
    logic            wr;
    logic            rd;

    assign full_o  = (count_q == CntMax);
    assign empty_o = (count_q == '0);
    assign wr      = push_i & (~full_o | pop_i);
    assign rd      = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + PtrOne;
            if (rd) rptr_q <= rptr_q + PtrOne;
            unique case ({wr, rd})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sifive_insight_tlb_capture.sv
// Passive B-channel capture: timestamps and beat-tags each fired beat and queues it for the
// trace encoder. SIFIVE_INSIGHT_TLB_DATA_EN enables capture of mask/data/corrupt.
module sifive_insight_tlb_capture
    import sifive_insight_tlb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TS_W   = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              b_valid,
    input  logic              b_ready,
    input  logic [2:0]        b_opcode,
    input  logic [1:0]        b_param,
    input  logic [3:0]        b_size,
    input  logic              b_source,
    input  logic [31:0]       b_address,
    input  logic [3:0]        b_mask,
    input  logic [31:0]       b_data,
    input  logic              b_corrupt,
    input  logic              cap_enable,
    output logic              rec_valid,
    input  logic              rec_ready,
    output capture_rec_t      rec,
    output logic [DROP_W-1:0] drop_count,
    output logic              overflow
);

    logic [TS_W-1:0]   ts_q;
    logic [7:0]        beat_q;
    logic [DROP_W-1:0] drop_q;
    logic              ovf_q;

    logic         fire;
    logic         push;
    logic         pop;
    logic         drop;
    logic         fifo_push;
    logic         fifo_full;
    logic         fifo_empty;
    logic [8:0]   beats;
    logic         is_last;
    capture_rec_t rec_d;
    capture_rec_t head;

    assign fire    = b_valid & b_ready;
    assign push    = fire & cap_enable;
    assign rec_valid = ~fifo_empty;
    assign pop     = rec_valid & rec_ready;
    // A full FIFO still takes the new beat when the head leaves in the same cycle.
    assign fifo_push = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;

    assign beats   = beats_of(b_opcode, b_size);
    assign is_last = ({1'b0, beat_q} == beats - 9'd1);

    always_comb begin
        rec_d          = '0;
        rec_d.ts       = RecTsW'(ts_q);
        rec_d.opcode   = b_opcode;
        rec_d.param    = b_param;
        rec_d.size     = b_size;
        rec_d.source   = b_source;
        rec_d.address  = b_address;
`ifdef SIFIVE_INSIGHT_TLB_DATA_EN
        rec_d.mask     = b_mask;
        rec_d.data     = b_data;
        rec_d.corrupt  = b_corrupt;
`endif
        rec_d.beat_idx = beat_q;
        rec_d.first    = (beat_q == 8'd0);
        rec_d.last     = is_last;
    end

`ifndef SIFIVE_INSIGHT_TLB_DATA_EN
    logic unused_payload;
    assign unused_payload = ^{b_mask, b_data, b_corrupt};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q   <= '0;
            beat_q <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            // Beat tracking follows every fire so indices stay aligned even when not captured.
            if (fire) begin
                beat_q <= is_last ? 8'd0 : beat_q + 8'd1;
            end
            if (drop) begin
                if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
                ovf_q <= 1'b1;
            end
        end
    end

    sifive_insight_capture_fifo #(
        .DEPTH (DEPTH),
        .T     (capture_rec_t)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (rec_d),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rec        = rec_valid ? head : '0;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule
